// File: rtl/gb_pkg.sv
// Shared constants for the DMG timer/divider: register map, TIMA clock-source
// selection and the interrupt-controller bit this block drives.
package gb_pkg;
    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    localparam int IRQ_TIMER_BIT = 2;

    // TAC[1:0] picks the system-counter bit whose falling edge clocks TIMA; TAC[2] gates it.
    function automatic logic timer_in(input logic [2:0] tac, input logic [15:0] cnt);
        logic b;
        case (tac[1:0])
            2'b00:   b = cnt[9];
            2'b01:   b = cnt[3];
            2'b10:   b = cnt[5];
            default: b = cnt[7];
        endcase
        return tac[2] & b;
    endfunction
endpackage

// File: rtl/gb_timer.sv
// DMG timer/divider at FF04-FF07: free-running system counter, TIMA clocked by a
// falling edge of a selected counter bit, delayed TMA reload and timer IRQ pulse.
module gb_timer
    import gb_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [7:0]  Di,
    output logic [7:0]  Do,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    output logic        irq_timer
);
    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [0:0]    ST_RUN    = 1'b0;
    localparam logic [0:0]    ST_RELOAD = 1'b1;

    logic [PW-1:0] ps_q, ps_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    tima_q, tima_d;
    logic [7:0]    tma_q, tma_d;
    logic [2:0]    tac_q, tac_d;
    logic [0:0]    state_q, state_d;
    logic [1:0]    rcnt_q, rcnt_d;
    logic          irq_q, irq_d;
    logic          inc_prev_q;
    logic          wr_prev_q;

    logic tick, wr_act, commit, inc_now, inc_fall;

    assign tick   = (ps_q == PS_LAST);
    assign wr_act = cs & wr;
    assign commit = wr_act & ~wr_prev_q;

    always_comb begin
        ps_d  = tick ? '0 : ps_q + PW'(1);
        cnt_d = tick ? cnt_q + 16'd1 : cnt_q;
        tma_d = tma_q;
        tac_d = tac_q;
        if (commit) begin
            case (A)
                ADDR_DIV: begin
                    cnt_d = '0;
                    ps_d  = '0;
                end
                ADDR_TMA: tma_d = Di;
                ADDR_TAC: tac_d = Di[2:0];
                default: ;
            endcase
        end
    end

    // Edge is taken on the next-state input so DIV/TAC writes glitch TIMA in the same clk.
    assign inc_now  = timer_in(tac_d, cnt_d);
    assign inc_fall = inc_prev_q & ~inc_now;

    always_comb begin
        tima_d  = tima_q;
        state_d = state_q;
        rcnt_d  = rcnt_q;
        irq_d   = 1'b0;
        if (commit && (A == ADDR_TIMA)) begin
            tima_d  = Di;
            state_d = ST_RUN;
        end else if ((state_q == ST_RELOAD) && tick && (rcnt_q == 2'd3)) begin
            tima_d  = tma_d;
            irq_d   = 1'b1;
            state_d = ST_RUN;
        end else begin
            if ((state_q == ST_RELOAD) && tick) rcnt_d = rcnt_q + 2'd1;
            if (inc_fall) begin
                if ((state_q == ST_RUN) && (tima_q == 8'hFF)) begin
                    tima_d  = '0;
                    rcnt_d  = '0;
                    state_d = ST_RELOAD;
                end else begin
                    tima_d = tima_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q       <= '0;
            cnt_q      <= '0;
            tima_q     <= '0;
            tma_q      <= '0;
            tac_q      <= '0;
            state_q    <= ST_RUN;
            rcnt_q     <= '0;
            irq_q      <= 1'b0;
            inc_prev_q <= 1'b0;
            wr_prev_q  <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            cnt_q      <= cnt_d;
            tima_q     <= tima_d;
            tma_q      <= tma_d;
            tac_q      <= tac_d;
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            irq_q      <= irq_d;
            inc_prev_q <= inc_now;
            wr_prev_q  <= wr_act;
        end
    end

    always_comb begin
        Do = 8'h00;
        if (cs & rd) begin
            case (A)
                ADDR_DIV:  Do = cnt_q[15:8];
                ADDR_TIMA: Do = tima_q;
                ADDR_TMA:  Do = tma_q;
                ADDR_TAC:  Do = {5'b11111, tac_q};
                default:   Do = 8'h00;
            endcase
        end
    end

    assign irq_timer = irq_q;
endmodule

// File: tb/tb_gb_timer.sv
// Bench for gb_timer: per-cycle reference model of the timer registers plus
// directed scenarios with hand-computed register values.
module tb_gb_timer;
    import gb_pkg::*;

    localparam int TD = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  Di = 8'h00;
    logic [7:0]  Do;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        irq_timer;

    int checks = 0;
    int errors = 0;

    gb_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .Di(Di), .Do(Do),
        .cs(cs), .wr(wr), .rd(rd), .irq_timer(irq_timer)
    );

    always #5 clk = ~clk;

    // Reference model: counters as plain numbers, pending reload as a tick countdown.
    logic [15:0] m_cnt;
    int          m_ps;
    logic [7:0]  m_tima, m_tma;
    logic [2:0]  m_tac;
    int          m_reload;
    bit          m_irq, m_wrp;

    function automatic bit sel_in(input logic [2:0] t, input logic [15:0] c);
        int idx;
        case (t[1:0])
            2'd0: idx = 9;
            2'd1: idx = 3;
            2'd2: idx = 5;
            default: idx = 7;
        endcase
        return t[2] && c[idx];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_ps = 0; m_tima = 0; m_tma = 0; m_tac = 0;
            m_reload = 0; m_irq = 0; m_wrp = 0;
        end else begin
            bit tick, wedge, was_in, fall;
            logic [15:0] n_cnt;
            logic [7:0]  n_tma;
            logic [2:0]  n_tac;
            tick   = (m_ps == TD - 1);
            wedge  = cs && wr && !m_wrp;
            m_wrp  = cs && wr;
            was_in = sel_in(m_tac, m_cnt);
            n_cnt  = tick ? m_cnt + 16'd1 : m_cnt;
            m_ps   = tick ? 0 : m_ps + 1;
            n_tma  = m_tma;
            n_tac  = m_tac;
            if (wedge && A == ADDR_DIV) begin n_cnt = 0; m_ps = 0; end
            if (wedge && A == ADDR_TMA) n_tma = Di;
            if (wedge && A == ADDR_TAC) n_tac = Di[2:0];
            fall  = was_in && !sel_in(n_tac, n_cnt);
            m_irq = 0;
            if (wedge && A == ADDR_TIMA) begin
                m_tima   = Di;
                m_reload = 0;
            end else if (m_reload > 0 && tick) begin
                m_reload--;
                if (m_reload == 0) begin m_tima = n_tma; m_irq = 1; end
                else if (fall) m_tima++;
            end else if (fall) begin
                if (m_reload == 0 && m_tima == 8'hFF) begin m_tima = 0; m_reload = 4; end
                else m_tima++;
            end
            m_cnt = n_cnt; m_tma = n_tma; m_tac = n_tac;
        end
    end

    function automatic logic [7:0] exp_do();
        if (!(cs && rd)) return 8'h00;
        case (A)
            ADDR_DIV:  return m_cnt[15:8];
            ADDR_TIMA: return m_tima;
            ADDR_TMA:  return m_tma;
            ADDR_TAC:  return {5'b11111, m_tac};
            default:   return 8'h00;
        endcase
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %02h want %02h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("do_vs_model", Do, exp_do());
            check("irq_vs_model", {7'b0, irq_timer}, {7'b0, m_irq});
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Short peek between edges: drives the read, samples combinational Do, releases.
    task automatic rd_reg(input logic [15:0] a, input logic [7:0] exp, input string nm);
        A = a; cs = 1'b1; rd = 1'b1;
        #1;
        check(nm, Do, exp);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d, input int hold);
        A = a; Di = d; cs = 1'b1; wr = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        check("irq_reset", {7'b0, irq_timer}, 8'h00);
        rd_reg(ADDR_DIV,  8'h00, "div_reset");
        rd_reg(ADDR_TIMA, 8'h00, "tima_reset");
        wait_clk(1);
        rd_reg(ADDR_TMA,  8'h00, "tma_reset");
        rd_reg(ADDR_TAC,  8'hF8, "tac_reset");

        // Counting on bit3: counter zeroed at commit edge E0, TAC=05 at E2
        wr_reg(ADDR_DIV, 8'h77, 1);
        wr_reg(ADDR_TAC, 8'h05, 1);
        wait_clk(12);
        rd_reg(ADDR_TIMA, 8'h00, "tima_before_16");
        wait_clk(1);
        rd_reg(ADDR_TIMA, 8'h01, "tima_at_16");
        check("model_tima_16", m_tima, 8'h01);
        wait_clk(240);
        rd_reg(ADDR_TIMA, 8'h10, "tima_at_256");
        rd_reg(ADDR_DIV,  8'h01, "div_at_256");

        // Overflow FE->FF->00, reload TMA=AB after 4 ticks
        wr_reg(ADDR_TMA,  8'hAB, 1);
        wr_reg(ADDR_TIMA, 8'hFE, 1);
        wait_clk(28);
        rd_reg(ADDR_TIMA, 8'h00, "tima_ovf_first");
        check("irq_during_reload", {7'b0, irq_timer}, 8'h00);
        wait_clk(3);
        rd_reg(ADDR_TIMA, 8'h00, "tima_ovf_last");
        wait_clk(1);
        rd_reg(ADDR_TIMA, 8'hAB, "tima_reloaded");
        check("irq_pulse", {7'b0, irq_timer}, 8'h01);
        check("model_irq", {7'b0, m_irq}, 8'h01);
        wait_clk(1);
        check("irq_one_clk", {7'b0, irq_timer}, 8'h00);

        // Overflow then CPU write during reload cancels reload and irq
        wr_reg(ADDR_TIMA, 8'hFF, 1);
        wait_clk(9);
        rd_reg(ADDR_TIMA, 8'h00, "tima_ovf2");
        wr_reg(ADDR_TIMA, 8'h55, 1);
        rd_reg(ADDR_TIMA, 8'h55, "tima_write_in_reload");
        for (int i = 0; i < 6; i++) begin
            wait_clk(1);
            check("irq_cancelled", {7'b0, irq_timer}, 8'h00);
        end
        wait_clk(2);

        // DIV write while selected bit is high: glitch increment
        rd_reg(ADDR_TIMA, 8'h55, "tima_pre_div_glitch");
        wr_reg(ADDR_DIV, 8'h00, 1);
        rd_reg(ADDR_DIV,  8'h00, "div_cleared");
        rd_reg(ADDR_TIMA, 8'h56, "tima_div_glitch");

        // Write held 5 clk across a counting edge commits only once
        wait_clk(12);
        wr_reg(ADDR_TIMA, 8'h10, 5);
        rd_reg(ADDR_TIMA, 8'h11, "tima_held_write");

        // CPU write to TIMA on the same clk as an increment: write wins
        wait_clk(12);
        wr_reg(ADDR_TIMA, 8'h20, 1);
        rd_reg(ADDR_TIMA, 8'h20, "tima_write_wins");

        // TAC write moving selection off a high bit: glitch increment
        wait_clk(8);
        wr_reg(ADDR_TAC, 8'h04, 1);
        rd_reg(ADDR_TIMA, 8'h21, "tima_tac_glitch");
        rd_reg(ADDR_TAC,  8'hFC, "tac_readback");

        // Reset in the middle of a reload
        wr_reg(ADDR_TAC,  8'h05, 1);
        wr_reg(ADDR_TIMA, 8'hFF, 1);
        n = 0;
        while (m_reload == 0 && n < 64) begin wait_clk(1); n++; end
        if (m_reload == 0) begin
            errors++;
            $display("FAIL reload_wait timed out after %0d clk, want overflow", n);
        end
        #2 rst_n = 1'b0;
        rd_reg(ADDR_TIMA, 8'h00, "tima_in_reset");
        rd_reg(ADDR_TAC,  8'hF8, "tac_in_reset");
        wait_clk(1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_clk(1);
            check("irq_after_reset", {7'b0, irq_timer}, 8'h00);
        end

        // Random register traffic, checked by the model every cycle
        for (int k = 0; k < 300; k++) begin
            int op;
            logic [1:0] r;
            logic [7:0] d;
            op = $urandom_range(0, 9);
            if (op < 6) begin
                r = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                if (r == 2'd0 && $urandom_range(0, 3) != 0) r = 2'd1;
                if (r == 2'd1 && $urandom_range(0, 1) == 1) d = 8'hF8 | 8'($urandom_range(0, 7));
                if (r == 2'd3) d[2] = ($urandom_range(0, 3) != 0);
                wr_reg(ADDR_DIV + 16'(r), d, $urandom_range(1, 3));
            end else if (op < 8) begin
                A = ADDR_DIV + 16'($urandom_range(0, 4));
                cs = 1'b1; rd = 1'b1;
                wait_clk(1);
                cs = 1'b0; rd = 1'b0;
            end else begin
                wait_clk($urandom_range(1, 4));
            end
        end

        wait_clk(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
